// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage between execute and writeback.
// Loads and stores go to an internal word-organised data memory with a
// fixed access latency; upstream is stalled while an access is in flight.
// Optional feature macro: MEM_SUBWORD_EN enables byte/halfword accesses
// (lane selection, sign/zero extension, byte-masked stores). Without it
// every access is a full word and size/load_unsigned are ignored.
module mem_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] read_data_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_count;

    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [4:0]    r_rd;
    logic          r_regWrite;
    logic          r_memToReg;

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_memOp;
    logic          w_misalign;
    logic          w_accept;
    logic          w_countZero;
    logic          w_commit;
    logic [AW-1:0] w_wordIdx;
    logic [31:0]   w_memWord;
    logic [3:0]    w_mask;
    logic [31:0]   w_storeData;
    logic [31:0]   w_loadData;
    logic          w_unused;

    assign w_memOp     = valid_in & (mem_read | mem_write);
    assign w_accept    = (r_state == IDLE) & w_memOp & ~w_misalign;
    assign w_countZero = (r_count == '0);
    assign w_commit    = (r_state == BUSY) & w_countZero;
    assign w_wordIdx   = r_addr[AW+1:2];
    assign w_memWord   = r_mem[w_wordIdx];

`ifdef MEM_SUBWORD_EN
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] w_byteShift;
    logic [31:0] w_halfShift;

    assign w_unused    = ^{address[31:AW+2]};
    assign w_byteShift = w_memWord >> {r_addr[1:0], 3'b000};
    assign w_halfShift = w_memWord >> {r_addr[1], 4'b0000};

    // Alignment rule depends on access size: bytes never misalign
    always_comb begin
        w_misalign = 1'b0;
        case (size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = address[0];
            default: w_misalign = (address[1:0] != 2'b00);
        endcase
    end

    // Byte-lane mask and lane-replicated store data from the captured op
    always_comb begin
        w_mask      = 4'b1111;
        w_storeData = r_wdata;
        case (r_size)
            2'b00: begin
                w_mask      = 4'b0001 << r_addr[1:0];
                w_storeData = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_mask      = r_addr[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{r_wdata[15:0]}};
            end
            default: begin
                w_mask      = 4'b1111;
                w_storeData = r_wdata;
            end
        endcase
    end

    // Select the addressed lane and extend it to 32 bits
    always_comb begin
        w_loadData = w_memWord;
        case (r_size)
            2'b00: w_loadData = r_unsigned ? {24'b0, w_byteShift[7:0]}
                                           : {{24{w_byteShift[7]}}, w_byteShift[7:0]};
            2'b01: w_loadData = r_unsigned ? {16'b0, w_halfShift[15:0]}
                                           : {{16{w_halfShift[15]}}, w_halfShift[15:0]};
            default: w_loadData = w_memWord;
        endcase
    end

    // Capture the sub-word controls alongside the rest of the operation
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_size     <= size;
            r_unsigned <= load_unsigned;
        end
    end
`else
    assign w_unused    = ^{address[31:AW+2], size, load_unsigned};
    assign w_misalign  = (address[1:0] != 2'b00);
    assign w_mask      = 4'b1111;
    assign w_storeData = r_wdata;
    assign w_loadData  = w_memWord;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state: enter BUSY on an aligned memory op, leave when count expires
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = BUSY;
            BUSY:    if (w_countZero) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Stall is high from acceptance until the final access cycle
    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = w_accept;
            BUSY:    stall = ~w_countZero;
            default: stall = 1'b0;
        endcase
    end

    // Capture the operation on acceptance and count down the access latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_regWrite <= 1'b0;
            r_memToReg <= 1'b0;
        end else if (w_accept) begin
            r_count    <= CW'(LATENCY - 1);
            r_write    <= mem_write;
            r_addr     <= address;
            r_wdata    <= write_data;
            r_rd       <= rd_in;
            r_regWrite <= reg_write_in;
            r_memToReg <= mem_to_reg_in;
        end else if (r_state == BUSY && !w_countZero) begin
            r_count    <= r_count - 1'b1;
        end
    end

    // Commit the store on the final access cycle unless reset aborts it
    always_ff @(posedge clk) begin
        if (reset && w_commit && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) r_mem[w_wordIdx][8*b +: 8] <= w_storeData[8*b +: 8];
            end
        end
    end

    // Registered results toward writeback
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out      <= 1'b0;
            alu_result_out <= '0;
            read_data_out  <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            misalign       <= 1'b0;
        end else if (w_commit) begin
            valid_out      <= 1'b1;
            alu_result_out <= r_addr;
            read_data_out  <= r_write ? 32'h0 : w_loadData;
            rd_out         <= r_rd;
            reg_write_out  <= r_regWrite;
            mem_to_reg_out <= r_memToReg;
            misalign       <= 1'b0;
        end else if (r_state == IDLE && valid_in && !w_accept) begin
            valid_out      <= 1'b1;
            alu_result_out <= address;
            read_data_out  <= 32'h0;
            rd_out         <= rd_in;
            reg_write_out  <= w_memOp ? 1'b0 : reg_write_in;
            mem_to_reg_out <= mem_to_reg_in;
            misalign       <= w_memOp;
        end else begin
            valid_out      <= 1'b0;
            reg_write_out  <= 1'b0;
            misalign       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed testbench for mem_stage (DEPTH_WORDS=256, LATENCY=2).
// Sub-word vectors are built only when MEM_SUBWORD_EN is defined; otherwise
// the word-only behaviour of the same accesses is checked instead.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic        stall;
    logic        valid_out;
    logic [31:0] alu_result_out;
    logic [31:0] read_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        misalign;

    int vectorCount = 0;
    int missCount   = 0;
    int sc;

    mem_stage #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .load_unsigned(load_unsigned),
        .address(address), .write_data(write_data), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .stall(stall), .valid_out(valid_out), .alu_result_out(alu_result_out),
        .read_data_out(read_data_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .misalign(misalign)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rdReq, input logic wrReq,
                                 input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rdIdx, input logic rw, input logic m2r);
        valid_in      = v;
        mem_read      = rdReq;
        mem_write     = wrReq;
        size          = sz;
        load_unsigned = uns;
        address       = addr;
        write_data    = wdata;
        rd_in         = rdIdx;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
    endtask

    // Hold the op while stall is high, then let it advance; returns stall cycle count
    task automatic runOp(output int stallCycles);
        stallCycles = 0;
        #1;
        while (stall === 1'b1 && stallCycles < 20) begin
            stallCycles++;
            @(posedge clk); #1;
        end
        if (stallCycles >= 20) checkOutput("stall timeout", 32'(stallCycles), 32'd2);
        @(posedge clk); #1;
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [1:0] sz,
                           input logic [31:0] data, input string tag);
        int s;
        applyStimulus(1'b1, 1'b0, 1'b1, sz, 1'b0, addr, data, 5'd0, 1'b0, 1'b0);
        runOp(s);
        checkOutput({tag, " stall"}, 32'(s), 32'd2);
        checkOutput({tag, " valid"}, 32'(valid_out), 32'd1);
        checkOutput({tag, " rdata"}, read_data_out, 32'h0);
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] expData, input string tag);
        int s;
        applyStimulus(1'b1, 1'b1, 1'b0, sz, uns, addr, 32'h0, 5'd3, 1'b1, 1'b1);
        runOp(s);
        checkOutput({tag, " stall"}, 32'(s), 32'd2);
        checkOutput({tag, " data"}, read_data_out, expData);
        checkOutput({tag, " valid"}, 32'(valid_out), 32'd1);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset valid", 32'(valid_out), 32'd0);
        checkOutput("reset alu", alu_result_out, 32'h0);
        checkOutput("reset rdata", read_data_out, 32'h0);
        checkOutput("reset rd", 32'(rd_out), 32'd0);
        checkOutput("reset misalign", 32'(misalign), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Word store then load, latency 2
        doStore(32'h10, 2'b10, 32'hDEADBEEF, "st10");
        checkOutput("st10 alu", alu_result_out, 32'h10);
        checkOutput("st10 regwrite", 32'(reg_write_out), 32'd0);
        @(posedge clk); #1;
        checkOutput("st10 pulse", 32'(valid_out), 32'd0);
        doLoad(32'h10, 2'b10, 1'b0, 32'hDEADBEEF, "ld10");
        checkOutput("ld10 m2r", 32'(mem_to_reg_out), 32'd1);
        checkOutput("ld10 rd", 32'(rd_out), 32'd3);

        // Sub-word lanes on word 0x80FF7F01 at 0x20
        doStore(32'h20, 2'b10, 32'h80FF7F01, "st20");
`ifdef MEM_SUBWORD_EN
        doLoad(32'h21, 2'b00, 1'b0, 32'h0000007F, "lb21");
        doLoad(32'h23, 2'b00, 1'b0, 32'hFFFFFF80, "lb23");
        doLoad(32'h23, 2'b00, 1'b1, 32'h00000080, "lbu23");
        doLoad(32'h22, 2'b01, 1'b0, 32'hFFFF80FF, "lh22");
        doStore(32'h20, 2'b00, 32'h123456AA, "sb20");
        doLoad(32'h20, 2'b10, 1'b0, 32'h80FF7FAA, "lw20b");
`else
        doLoad(32'h20, 2'b10, 1'b0, 32'h80FF7F01, "lw20");
        // size is ignored: a byte access at 0x21 follows the word alignment rule
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 5'd4, 1'b1, 1'b1);
        runOp(sc);
        checkOutput("lb21 stall", 32'(sc), 32'd0);
        checkOutput("lb21 misalign", 32'(misalign), 32'd1);
`endif

        // Misaligned word load and store: no stall, no access
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 5'd6, 1'b1, 1'b1);
        runOp(sc);
        checkOutput("mis ld stall", 32'(sc), 32'd0);
        checkOutput("mis ld valid", 32'(valid_out), 32'd1);
        checkOutput("mis ld flag", 32'(misalign), 32'd1);
        checkOutput("mis ld regwrite", 32'(reg_write_out), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0);
        runOp(sc);
        checkOutput("mis st flag", 32'(misalign), 32'd1);
`ifdef MEM_SUBWORD_EN
        doLoad(32'h20, 2'b10, 1'b0, 32'h80FF7FAA, "mis unchanged");
`else
        doLoad(32'h20, 2'b10, 1'b0, 32'h80FF7F01, "mis unchanged");
`endif

        // Non-memory op passes through with latency 1
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
        runOp(sc);
        checkOutput("alu stall", 32'(sc), 32'd0);
        checkOutput("alu result", alu_result_out, 32'h1234);
        checkOutput("alu rd", 32'(rd_out), 32'd5);
        checkOutput("alu valid", 32'(valid_out), 32'd1);
        checkOutput("alu regwrite", 32'(reg_write_out), 32'd1);
        checkOutput("alu rdata", read_data_out, 32'h0);
        checkOutput("alu misalign", 32'(misalign), 32'd0);

        // Reset in the final BUSY cycle aborts the store
        doStore(32'h40, 2'b10, 32'h22222222, "st40 old");
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, 5'd9, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort lastcycle stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort valid", 32'(valid_out), 32'd0);
        checkOutput("abort alu", alu_result_out, 32'h0);
        checkOutput("abort regwrite", 32'(reg_write_out), 32'd0);
        checkOutput("abort rd", 32'(rd_out), 32'd0);
        reset = 1'b1;
        valid_in = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        doLoad(32'h40, 2'b10, 1'b0, 32'h22222222, "abort retained");

        // Address wrap modulo 1 KiB and store-over-load priority
        doStore(32'h400, 2'b10, 32'hCAFEF00D, "st400");
        doLoad(32'h000, 2'b10, 1'b0, 32'hCAFEF00D, "wrap ld0");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h5555AAAA, 5'd2, 1'b0, 1'b0);
        runOp(sc);
        checkOutput("prio stall", 32'(sc), 32'd2);
        checkOutput("prio rdata", read_data_out, 32'h0);
        doLoad(32'h8, 2'b10, 1'b0, 32'h5555AAAA, "prio ld8");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes the registered ALU result as the effective address and rt as store data.
- Performs loads and stores against an internal word-organised data memory with a fixed multi-cycle access latency.
- Stalls upstream while an access is in flight; drives registered results and writeback controls to the writeback stage.

Parameters:
DEPTH_WORDS, 256, number of 32-bit memory words; power of two.
LATENCY, 2, access cycles per memory operation; minimum 1.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
valid_in  input  1  upstream operation valid
mem_read  input  1  load request
mem_write  input  1  store request
size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word
load_unsigned  input  1  1 zero-extends sub-word loads; 0 sign-extends
address  input  32  effective address from execute
write_data  input  32  store data (rt)
rd_in  input  5  destination register
reg_write_in  input  1  writeback enable
mem_to_reg_in  input  1  writeback selects memory data
stall  output  1  upstream must hold inputs stable (combinational)
valid_out  output  1  registered result valid
alu_result_out  output  32  registered copy of address
read_data_out  output  32  registered load data, extended
rd_out  output  5  registered rd_in
reg_write_out  output  1  registered writeback enable
mem_to_reg_out  output  1  registered mem_to_reg_in
misalign  output  1  registered misaligned-access flag

Behaviour:
- Reset (reset==0 at rising edge): state IDLE, counter 0, all outputs 0. Memory contents are not cleared. A reset in any BUSY cycle aborts the operation; no store is committed.
- Memory op means valid_in & (mem_read | mem_write). If both are set, the op is a store and the read is ignored.
- Word index is address[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Little-endian byte lanes: byte lane address[1:0]; halfword lane address[1].
- Misaligned: halfword with address[0]=1, or word with address[1:0]!=0.
- FSM states: IDLE and BUSY.
  - IDLE, valid_in=0: next cycle valid_out=0, reg_write_out=0, misalign=0.
  - IDLE, valid non-memory op: no stall. Next cycle valid_out=1 and pass-through fields are registered; read_data_out=0. Latency 1.
  - IDLE, misaligned memory op: no stall, no access. Next cycle valid_out=1, misalign=1, reg_write_out=0.
  - IDLE, aligned memory op: stall=1 combinationally. Capture all inputs, counter=LATENCY-1, go to BUSY.
  - BUSY, counter!=0: stall=1, counter decrements.
  - BUSY, counter==0: stall=0 (upstream advances on this edge). Commit the store as a byte-lane masked write, or read the word. Register outputs, return to IDLE.
  - While in BUSY, inputs are ignored; only captured values are used.
- Memory op latency: presented in cycle 0, valid_out high in cycle LATENCY+1. stall is high for exactly LATENCY cycles (cycles 0..LATENCY-1).
- Store: read_data_out=0. reg_write_out follows the captured reg_write_in.
- Load: lane selected, then sign- or zero-extended to 32 bits per load_unsigned.
- valid_out pulses for one cycle per accepted op. It stays 0 in cycles where no op completes.
- Back-to-back memory ops: the next op is presented in the cycle after stall falls and is accepted from IDLE with no bubble beyond the FSM itself.

Optional Feature:
MEM_SUBWORD_EN
- Defined: byte and halfword loads/stores as described.
- Undefined: size is ignored and every access is a word. Only the word misalignment rule applies. No byte-lane masking; stores write all 4 bytes. Loads return the full word, and load_unsigned is ignored.

Test Plan:
- Word store then load, LATENCY=2: store 0xDEADBEEF at 0x10; stall high 2 cycles; valid_out in cycle 3. Load 0x10 -> read_data_out=0xDEADBEEF, mem_to_reg_out=1.
- Sub-word (MEM_SUBWORD_EN): memory word 0x80FF7F01 at 0x20.
  - Load byte 0x21 signed -> 0x0000007F.
  - Load byte 0x23 signed -> 0xFFFFFF80.
  - Load byte 0x23 unsigned -> 0x00000080.
  - Load half 0x22 signed -> 0xFFFF80FF.
  - Store byte 0xAA at 0x20 -> word reads 0x80FF7FAA.
- Misalign: load word at 0x22 -> no stall; next cycle misalign=1, valid_out=1, reg_write_out=0; memory unchanged.
- Non-memory op: address=0x1234, rd_in=5, reg_write_in=1 -> next cycle alu_result_out=0x1234, rd_out=5, valid_out=1, stall never high.
- Reset mid-op: store 0x11111111 at 0x40, reset low in the BUSY counter==0 cycle -> outputs all 0, word at 0x40 retains its old value.
- Wrap and priority: with DEPTH_WORDS=256, store to 0x400 then load 0x000 -> same data. mem_read and mem_write both set -> treated as store, read_data_out=0.
